// File: rtl/uart_param.sv
// Parametrised full-duplex UART: TX starts the cycle after tx_start_tick and ignores requests while busy.
// RX pushes to the FIFO on the mid-stop sample (+2 sync cycles); a full FIFO drops the frame and flags overrun.
module uart_param #(
   parameter int CLK_PER_BIT   = 1250,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int RX_FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic                 tx,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_start_tick,
   output logic                 tx_busy,
   output logic                 tx_done_tick,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_read_tick,
   output logic                 rx_ready_tick,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun,
   input  logic                 rx_err_clear
);
   localparam int CW = $clog2(CLK_PER_BIT);
   localparam int AW = $clog2(RX_FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_MAX  = CW'(CLK_PER_BIT / 2 - 1);
   localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY == 2);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(RX_FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

   state_t                tx_state;
   logic [CW-1:0]         tx_cnt;
   logic [3:0]            tx_bit;
   logic [DATA_BITS-1:0]  tx_shift;
   logic                  tx_par;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state     <= S_IDLE;
         tx_cnt       <= '0;
         tx_bit       <= '0;
         tx_shift     <= '0;
         tx_par       <= 1'b0;
         tx           <= 1'b1;
         tx_busy      <= 1'b0;
         tx_done_tick <= 1'b0;
      end else begin
         tx_done_tick <= 1'b0;
         if (tx_state == S_IDLE) begin
            if (tx_start_tick) begin
               tx_shift <= tx_data;
               tx_par   <= (^tx_data) ^ PAR_ODD;
               tx       <= 1'b0;
               tx_busy  <= 1'b1;
               tx_cnt   <= '0;
               tx_state <= S_START;
            end
         end else if (tx_cnt != CNT_MAX) begin
            tx_cnt <= tx_cnt + 1'b1;
         end else begin
            tx_cnt <= '0;
            case (tx_state)
               S_START: begin
                  tx       <= tx_shift[0];
                  tx_bit   <= '0;
                  tx_state <= S_DATA;
               end
               S_DATA: begin
                  if (tx_bit != LAST_BIT) begin
                     tx_shift <= tx_shift >> 1;
                     tx       <= tx_shift[1];
                     tx_bit   <= tx_bit + 1'b1;
                  end else if (PARITY != 0) begin
                     tx       <= tx_par;
                     tx_state <= S_PARITY;
                  end else begin
                     tx       <= 1'b1;
                     tx_bit   <= '0;
                     tx_state <= S_STOP;
                  end
               end
               S_PARITY: begin
                  tx       <= 1'b1;
                  tx_bit   <= '0;
                  tx_state <= S_STOP;
               end
               S_STOP: begin
                  if (tx_bit != STOP_LAST) begin
                     tx_bit <= tx_bit + 1'b1;
                  end else begin
                     tx_busy      <= 1'b0;
                     tx_done_tick <= 1'b1;
                     tx_state     <= S_IDLE;
                  end
               end
               default: tx_state <= S_IDLE;
            endcase
         end
      end
   end

   logic                  rx_s1, rx_s2, rx_d;
   state_t                rx_state;
   logic [CW-1:0]         rx_cnt;
   logic [3:0]            rx_bit;
   logic [DATA_BITS-1:0]  rx_shift;
   logic                  rx_bad;
   logic                  sample, fall, par_exp, push, wr, pop, full;
   logic [DATA_BITS-1:0]  mem [RX_FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count;

   assign fall    = rx_d & ~rx_s2;
   assign sample  = (rx_state == S_START) ? (rx_cnt == HALF_MAX) : (rx_cnt == CNT_MAX);
   assign par_exp = (^rx_shift) ^ PAR_ODD;
   assign push    = (rx_state == S_STOP) && sample && rx_s2 && !rx_bad;
   assign full    = (count == FULL_CNT);
   assign pop     = rx_read_tick && (count != '0);
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign wr      = push && (!full || pop);
   assign rx_data  = mem[rd_ptr];
   assign rx_valid = (count != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1         <= 1'b1;
         rx_s2         <= 1'b1;
         rx_d          <= 1'b1;
         rx_state      <= S_IDLE;
         rx_cnt        <= '0;
         rx_bit        <= '0;
         rx_shift      <= '0;
         rx_bad        <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
         if (rx_state == S_IDLE || rx_state == S_WAIT_HIGH || sample)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;
         // Clear first so that a same-cycle error assignment below wins.
         if (rx_err_clear) begin
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
         end
         case (rx_state)
            S_IDLE: if (fall) rx_state <= S_START;
            S_START: if (sample) begin
               if (rx_s2) begin
                  rx_state <= S_IDLE;
               end else begin
                  rx_bit   <= '0;
                  rx_bad   <= 1'b0;
                  rx_state <= S_DATA;
               end
            end
            S_DATA: if (sample) begin
               rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
               if (rx_bit != LAST_BIT) rx_bit <= rx_bit + 1'b1;
               else rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (sample) begin
               if (rx_s2 != par_exp) begin
                  rx_bad        <= 1'b1;
                  rx_parity_err <= 1'b1;
               end
               rx_state <= S_STOP;
            end
            S_STOP: if (sample) begin
               if (!rx_s2) begin
                  rx_frame_err <= 1'b1;
                  rx_state     <= S_WAIT_HIGH;
               end else begin
                  rx_state <= S_IDLE;
               end
            end
            S_WAIT_HIGH: if (rx_s2) rx_state <= S_IDLE;
            default: rx_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RX_FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         rx_ready_tick <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_ready_tick <= wr;
         if (wr) begin
            mem[wr_ptr] <= rx_shift;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (wr && !pop) count <= count + 1'b1;
         else if (pop && !wr) count <= count - 1'b1;
         if (rx_err_clear) rx_overrun <= 1'b0;
         if (push && !wr) rx_overrun <= 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: default instance at 1250 clk/bit, plus fast instances for parity and FIFO cases.
module tb_uart_param;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [2:0] ser = 3'b111;
   int checks = 0;
   int errors = 0;

   logic       tx_a, tx_start_a = 0, tx_busy_a, tx_done_a, rx_valid_a, rx_read_a = 0;
   logic       rx_ready_a, ferr_a, perr_a, ovr_a, clr_a = 0;
   logic [7:0] tx_data_a = 0, rx_data_a;
   logic       tx_b, tx_start_b = 0, tx_busy_b, tx_done_b, rx_valid_b, rx_read_b = 0;
   logic       rx_ready_b, ferr_b, perr_b, ovr_b, clr_b = 0;
   logic [7:0] tx_data_b = 0, rx_data_b;
   logic       tx_c, tx_start_c = 0, tx_busy_c, tx_done_c, rx_valid_c, rx_read_c = 0;
   logic       rx_ready_c, ferr_c, perr_c, ovr_c, clr_c = 0;
   logic [6:0] tx_data_c = 0, rx_data_c;

   int rdy_a = 0, rdy_b = 0, rdy_c = 0;
   int busy_cnt_a = 0, busy_cnt_c = 0, done_cnt_a = 0, done_cnt_c = 0;

   always #5 clk = ~clk;

   uart_param dut_a (
      .clk(clk), .reset(reset), .rx(ser[0]), .tx(tx_a), .tx_data(tx_data_a),
      .tx_start_tick(tx_start_a), .tx_busy(tx_busy_a), .tx_done_tick(tx_done_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_read_tick(rx_read_a),
      .rx_ready_tick(rx_ready_a), .rx_frame_err(ferr_a), .rx_parity_err(perr_a),
      .rx_overrun(ovr_a), .rx_err_clear(clr_a));

   uart_param #(.CLK_PER_BIT(16)) dut_b (
      .clk(clk), .reset(reset), .rx(ser[1]), .tx(tx_b), .tx_data(tx_data_b),
      .tx_start_tick(tx_start_b), .tx_busy(tx_busy_b), .tx_done_tick(tx_done_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_read_tick(rx_read_b),
      .rx_ready_tick(rx_ready_b), .rx_frame_err(ferr_b), .rx_parity_err(perr_b),
      .rx_overrun(ovr_b), .rx_err_clear(clr_b));

   uart_param #(.CLK_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_c (
      .clk(clk), .reset(reset), .rx(ser[2]), .tx(tx_c), .tx_data(tx_data_c),
      .tx_start_tick(tx_start_c), .tx_busy(tx_busy_c), .tx_done_tick(tx_done_c),
      .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_read_tick(rx_read_c),
      .rx_ready_tick(rx_ready_c), .rx_frame_err(ferr_c), .rx_parity_err(perr_c),
      .rx_overrun(ovr_c), .rx_err_clear(clr_c));

   always @(posedge clk) begin
      if (rx_ready_a) rdy_a++;
      if (rx_ready_b) rdy_b++;
      if (rx_ready_c) rdy_c++;
      if (tx_busy_a) busy_cnt_a++;
      if (tx_busy_c) busy_cnt_c++;
      if (tx_done_a) done_cnt_a++;
      if (tx_done_c) done_cnt_c++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drives n frame bits LSB first onto one serial line; the line keeps the last bit.
   task automatic send_frame(input int which, input int cpb, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ser[which] = bits[i];
         repeat (cpb) @(negedge clk);
      end
   endtask

   // Called on the negedge right after the accepting edge; samples each bit at mid-bit.
   task automatic tx_capture(input int which, input int cpb, input int n, output logic [15:0] bits);
      int w;
      bits = '0;
      repeat (cpb / 2 - 1) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         bits[i] = (which == 0) ? tx_a : tx_c;
         w = cpb;
         if (which == 0 && i == 4) begin
            tx_data_a  = 8'hFF;
            tx_start_a = 1'b1;
            @(negedge clk);
            tx_start_a = 1'b0;
            w = cpb - 1;
         end
         if (i < n - 1) repeat (w) @(negedge clk);
      end
   endtask

   initial begin
      logic [15:0] bits;
      int base, base2;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_tx", tx_a, 1'b1);
      chk("rst_busy", tx_busy_a, 1'b0);
      chk("rst_done", tx_done_a, 1'b0);
      chk("rst_valid", rx_valid_a, 1'b0);
      chk("rst_rxdata", rx_data_a, 8'h00);
      chk("rst_flags", {ferr_a, perr_a, ovr_a, rx_ready_a}, 4'b0000);

      // RX 0x35 at 1250 clk/bit
      base = rdy_a;
      send_frame(0, 1250, 16'h026A, 10);
      repeat (5) @(negedge clk);
      chk("rx1_ready_cnt", rdy_a - base, 1);
      chk("rx1_valid", rx_valid_a, 1'b1);
      chk("rx1_data", rx_data_a, 8'h35);
      chk("rx1_flags", {ferr_a, perr_a, ovr_a}, 3'b000);
      repeat (20) @(negedge clk);
      chk("rx1_valid_hold", rx_valid_a, 1'b1);
      rx_read_a = 1'b1;
      @(negedge clk);
      rx_read_a = 1'b0;
      chk("rx1_valid_pop", rx_valid_a, 1'b0);

      // TX 0xBC, with an ignored second request mid-frame
      base = busy_cnt_a;
      base2 = done_cnt_a;
      tx_data_a = 8'hBC;
      tx_start_a = 1'b1;
      @(negedge clk);
      tx_start_a = 1'b0;
      tx_data_a = 8'h00;
      chk("tx2_start_low", tx_a, 1'b0);
      chk("tx2_busy_on", tx_busy_a, 1'b1);
      tx_capture(0, 1250, 10, bits);
      chk("tx2_frame", bits, 16'h0378);
      for (int k = 0; k < 3000 && tx_busy_a; k++) @(negedge clk);
      chk("tx2_busy_off", tx_busy_a, 1'b0);
      chk("tx2_done_first_idle", tx_done_a, 1'b1);
      @(negedge clk);
      chk("tx2_done_pulse", tx_done_a, 1'b0);
      chk("tx2_busy_cycles", busy_cnt_a - base, 12500);
      chk("tx2_done_cnt", done_cnt_a - base2, 1);

      // 7E2 even parity: TX 0x55 then RX with bad and good parity
      base = busy_cnt_c;
      base2 = done_cnt_c;
      tx_data_c = 7'h55;
      tx_start_c = 1'b1;
      @(negedge clk);
      tx_start_c = 1'b0;
      tx_capture(2, 16, 11, bits);
      chk("tx3_frame", bits, 16'h06AA);
      for (int k = 0; k < 100 && tx_busy_c; k++) @(negedge clk);
      @(negedge clk);
      chk("tx3_busy_cycles", busy_cnt_c - base, 176);
      chk("tx3_done_cnt", done_cnt_c - base2, 1);
      base = rdy_c;
      send_frame(2, 16, 16'h03AA, 10);
      repeat (5) @(negedge clk);
      chk("rx3_parity_err", perr_c, 1'b1);
      chk("rx3_no_push", rdy_c - base, 0);
      chk("rx3_valid", rx_valid_c, 1'b0);
      clr_c = 1'b1;
      @(negedge clk);
      clr_c = 1'b0;
      chk("rx3_clear", perr_c, 1'b0);
      send_frame(2, 16, 16'h0354, 10);
      repeat (5) @(negedge clk);
      chk("rx3_good_valid", rx_valid_c, 1'b1);
      chk("rx3_good_data", rx_data_c, 7'h2A);
      chk("rx3_good_noerr", {perr_c, ferr_c}, 2'b00);

      // Framing error, line held low, then a clean 0xA5
      base = rdy_b;
      send_frame(1, 16, 16'h0024, 10);
      repeat (48) @(negedge clk);
      ser[1] = 1'b1;
      repeat (32) @(negedge clk);
      send_frame(1, 16, 16'h034A, 10);
      repeat (5) @(negedge clk);
      chk("rx4_frame_err", ferr_b, 1'b1);
      chk("rx4_ready_cnt", rdy_b - base, 1);
      chk("rx4_data", rx_data_b, 8'hA5);
      chk("rx4_other_flags", {perr_b, ovr_b}, 2'b00);
      rx_read_b = 1'b1;
      clr_b = 1'b1;
      @(negedge clk);
      rx_read_b = 1'b0;
      clr_b = 1'b0;
      chk("rx4_cleared", ferr_b, 1'b0);
      chk("rx4_empty", rx_valid_b, 1'b0);

      // Five back-to-back frames into a 4-deep FIFO
      base = rdy_b;
      for (int v = 1; v <= 5; v++) send_frame(1, 16, {7'h01, v[7:0], 1'b0}, 10);
      repeat (5) @(negedge clk);
      chk("rx5_ready_cnt", rdy_b - base, 4);
      chk("rx5_overrun", ovr_b, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rx5_pop%0d", i), {rx_valid_b, rx_data_b}, {1'b1, 8'(i + 1)});
         rx_read_b = 1'b1;
         @(negedge clk);
         rx_read_b = 1'b0;
      end
      chk("rx5_empty", rx_valid_b, 1'b0);
      rx_read_b = 1'b1;
      @(negedge clk);
      rx_read_b = 1'b0;
      chk("rx5_empty_read", {rx_valid_b, rx_data_b}, {1'b0, 8'h01});
      chk("rx5_overrun_sticky", ovr_b, 1'b1);

      // 400-cycle glitch on the 1250 clk/bit line
      base = rdy_a;
      ser[0] = 1'b0;
      repeat (400) @(negedge clk);
      ser[0] = 1'b1;
      repeat (2000) @(negedge clk);
      chk("rx6_glitch_ready", rdy_a - base, 0);
      chk("rx6_glitch_flags", {rx_valid_a, ferr_a, perr_a, ovr_a}, 4'b0000);

      // Reset in the middle of a TX frame with data in a FIFO
      send_frame(1, 16, 16'h02EE, 10);
      repeat (5) @(negedge clk);
      chk("rst6_fifo_loaded", {rx_valid_b, rx_data_b}, {1'b1, 8'h77});
      tx_data_a = 8'h0F;
      tx_start_a = 1'b1;
      @(negedge clk);
      tx_start_a = 1'b0;
      repeat (3000) @(negedge clk);
      chk("rst6_busy_before", tx_busy_a, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst6_tx", tx_a, 1'b1);
      chk("rst6_busy", tx_busy_a, 1'b0);
      chk("rst6_fifo", {rx_valid_b, rx_data_b, ovr_b}, {1'b0, 8'h00, 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
